// File: rtl/char_state_handler_pkg.sv
// ---------------------------------------------------------------------------
// char_state_handler_pkg
// Shared definitions for the character action FSM: the state encoding used
// by the action FSM, the position handler and the sprite selector, plus
// small decode helpers for the attack states.
// No ports (package).
// ---------------------------------------------------------------------------
package char_state_handler_pkg;

    localparam int STATE_W = 4;
    localparam int CNT_W   = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE                = 4'd0,
        LEFT                = 4'd1,
        RIGHT               = 4'd2,
        ATTACK_START        = 4'd3,
        ATTACK_ACTIVE       = 4'd4,
        ATTACK_RECOVERY     = 4'd5,
        ATTACK_DIR_START    = 4'd6,
        ATTACK_DIR_ACTIVE   = 4'd7,
        ATTACK_DIR_RECOVERY = 4'd8
    } charState_e;

    // True in any of the six attack phases (neutral or directional).
    function automatic logic isAttackState(input charState_e s);
        return (s == ATTACK_START)     || (s == ATTACK_ACTIVE)     ||
               (s == ATTACK_RECOVERY)  || (s == ATTACK_DIR_START)  ||
               (s == ATTACK_DIR_ACTIVE)|| (s == ATTACK_DIR_RECOVERY);
    endfunction

    // True while the hitbox is out.
    function automatic logic isHitboxState(input charState_e s);
        return (s == ATTACK_ACTIVE) || (s == ATTACK_DIR_ACTIVE);
    endfunction

endpackage

// File: rtl/char_state_handler.sv
// ---------------------------------------------------------------------------
// char_state_handler
// Character action FSM. Turns the synchronised per-player buttons into the
// 4-bit character state consumed by the position and render blocks. One clock
// cycle is one game frame.
//
// Ports:
//   clk           in   frame clock
//   rst           in   synchronous active-low reset (0 = reset)
//   btn_left      in   left held, active-high
//   btn_right     in   right held, active-high
//   btn_attack    in   attack button, active-high (edge triggered)
//   state         out  registered character state
//   hitbox_active out  1 in ATTACK_ACTIVE / ATTACK_DIR_ACTIVE
//   busy          out  1 in any attack phase
//   frame_cnt     out  frames left in the current attack phase after this one
// ---------------------------------------------------------------------------
module char_state_handler
    import char_state_handler_pkg::*;
#(
    parameter logic [4:0] ATK_START_FR  = 5'd5,
    parameter logic [4:0] ATK_ACTIVE_FR = 5'd2,
    parameter logic [4:0] ATK_RECOV_FR  = 5'd16,
    parameter logic [4:0] DIR_START_FR  = 5'd4,
    parameter logic [4:0] DIR_ACTIVE_FR = 5'd3,
    parameter logic [4:0] DIR_RECOV_FR  = 5'd15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_attack,
    output logic [3:0]       state,
    output logic             hitbox_active,
    output logic             busy,
    output logic [4:0]       frame_cnt
);

    // A zero-length phase cannot be represented by the count-down scheme.
    if (ATK_START_FR == 5'd0 || ATK_ACTIVE_FR == 5'd0 || ATK_RECOV_FR == 5'd0 ||
        DIR_START_FR == 5'd0 || DIR_ACTIVE_FR == 5'd0 || DIR_RECOV_FR == 5'd0) begin : gBadPhaseLen
        $error("char_state_handler: attack phase frame counts must be 1..31");
    end

    charState_e       state_q, state_d;
    logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
    logic             atkDly_q;

    logic             atkRise;
    logic             dirHeld;
    charState_e       moveState;

    // Next-state decode. Attack phases count frameCnt down to zero and then
    // load the next phase length minus one, so each phase lasts exactly its
    // parameter in frames. Buttons are only looked at from free states, and
    // the last recovery frame only honours movement so attacks never chain.
    always_comb begin
        atkRise    = btn_attack & ~atkDly_q;
        dirHeld    = btn_left ^ btn_right;
        moveState  = IDLE;
        state_d    = state_q;
        frameCnt_d = frameCnt_q;

        if (btn_left & ~btn_right) begin
            moveState = LEFT;
        end else if (btn_right & ~btn_left) begin
            moveState = RIGHT;
        end

        case (state_q)
            IDLE, LEFT, RIGHT: begin
                if (atkRise & dirHeld) begin
                    state_d    = ATTACK_DIR_START;
                    frameCnt_d = DIR_START_FR - 5'd1;
                end else if (atkRise) begin
                    state_d    = ATTACK_START;
                    frameCnt_d = ATK_START_FR - 5'd1;
                end else begin
                    state_d    = moveState;
                    frameCnt_d = '0;
                end
            end
            ATTACK_START: begin
                if (frameCnt_q != '0) begin
                    frameCnt_d = frameCnt_q - 5'd1;
                end else begin
                    state_d    = ATTACK_ACTIVE;
                    frameCnt_d = ATK_ACTIVE_FR - 5'd1;
                end
            end
            ATTACK_ACTIVE: begin
                if (frameCnt_q != '0) begin
                    frameCnt_d = frameCnt_q - 5'd1;
                end else begin
                    state_d    = ATTACK_RECOVERY;
                    frameCnt_d = ATK_RECOV_FR - 5'd1;
                end
            end
            ATTACK_DIR_START: begin
                if (frameCnt_q != '0) begin
                    frameCnt_d = frameCnt_q - 5'd1;
                end else begin
                    state_d    = ATTACK_DIR_ACTIVE;
                    frameCnt_d = DIR_ACTIVE_FR - 5'd1;
                end
            end
            ATTACK_DIR_ACTIVE: begin
                if (frameCnt_q != '0) begin
                    frameCnt_d = frameCnt_q - 5'd1;
                end else begin
                    state_d    = ATTACK_DIR_RECOVERY;
                    frameCnt_d = DIR_RECOV_FR - 5'd1;
                end
            end
            ATTACK_RECOVERY, ATTACK_DIR_RECOVERY: begin
                if (frameCnt_q != '0) begin
                    frameCnt_d = frameCnt_q - 5'd1;
                end else begin
                    state_d    = moveState;
                    frameCnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                frameCnt_d = '0;
            end
        endcase
    end

    // State, phase counter and attack edge register. The edge register resets
    // to 1 so an attack button held through reset needs a fresh press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            frameCnt_q <= '0;
            atkDly_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            atkDly_q   <= btn_attack;
        end
    end

    assign state         = state_q;
    assign frame_cnt     = frameCnt_q;
    assign busy          = isAttackState(state_q);
    assign hitbox_active = isHitboxState(state_q);

endmodule

// File: tb/tb_char_state_handler.sv
// ---------------------------------------------------------------------------
// tb_char_state_handler
// Self-checking bench for char_state_handler. A timeline reference model
// predicts the outputs after every frame and pushes them into a queue; a
// separate monitor pops and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_char_state_handler;

    typedef struct {
        int st;
        int cnt;
    } expect_t;

    logic       clk;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic [3:0] state;
    logic       hitbox_active;
    logic       busy;
    logic [4:0] frame_cnt;

    int total;
    int bad;
    int cycleNo;

    expect_t expQ[$];
    expect_t plan[$];
    bit      prevAtk;
    bit      lastBusy;

    char_state_handler dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .state         (state),
        .hitbox_active (hitbox_active),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    // Free-running frame clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Append one attack phase to the timeline: len frames, counting down.
    task automatic addPhase(input int st, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            plan.push_back('{st, i});
        end
    endtask

    function automatic int moveOf(input bit l, input bit r);
        if (l && !r) return 1;
        if (r && !l) return 2;
        return 0;
    endfunction

    // Drive one frame of inputs and predict the outputs after the next edge.
    // An attack is modelled as a whole timeline of (state, frames-left)
    // entries queued at the moment it fires.
    task automatic applyStimulus(input bit r, input bit l, input bit rt, input bit a);
        expect_t e;
        bit      rise;
        @(negedge clk);
        rst        = r;
        btn_left   = l;
        btn_right  = rt;
        btn_attack = a;
        if (!r) begin
            plan.delete();
            prevAtk  = 1'b1;
            lastBusy = 1'b0;
            e = '{0, 0};
        end else begin
            rise    = a && !prevAtk;
            prevAtk = a;
            if (plan.size() > 0) begin
                e = plan.pop_front();
            end else if (!lastBusy && rise) begin
                if (l ^ rt) begin
                    addPhase(6, 4);
                    addPhase(7, 3);
                    addPhase(8, 15);
                end else begin
                    addPhase(3, 5);
                    addPhase(4, 2);
                    addPhase(5, 16);
                end
                e = plan.pop_front();
            end else begin
                e = '{moveOf(l, rt), 0};
            end
            lastBusy = (e.st >= 3) && (e.st <= 8);
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        bit expHit;
        bit expBusy;
        expHit  = (e.st == 4) || (e.st == 7);
        expBusy = (e.st >= 3) && (e.st <= 8);
        total++;
        if (state !== 4'(e.st) || frame_cnt !== 5'(e.cnt) ||
            hitbox_active !== expHit || busy !== expBusy) begin
            bad++;
            $display("[TB] FAIL frame%0d: got state=%0d cnt=%0d hit=%0b busy=%0b, want state=%0d cnt=%0d hit=%0b busy=%0b",
                     cycleNo, state, frame_cnt, hitbox_active, busy,
                     e.st, e.cnt, expHit, expBusy);
        end
    endtask

    // Monitor: one prediction is consumed per frame, sampled after the edge.
    initial begin
        expect_t e;
        cycleNo = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
                cycleNo++;
            end
        end
    end

    initial begin
        int waitCnt;
        total      = 0;
        bad        = 0;
        prevAtk    = 1'b1;
        lastBusy   = 1'b0;
        rst        = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_attack = 1'b1;

        $display("[TB] reset with attack held");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 1);

        $display("[TB] movement");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);

        $display("[TB] neutral attack");
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 26; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] directional attack");
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 1);
        for (int i = 0; i < 25; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] inputs during attack");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 22; i++)
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] abort during hitbox");
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] random frames");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 299) != 0),
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 3) == 0));
        end

        waitCnt = 0;
        while (expQ.size() > 0 && waitCnt < 10) begin
            @(posedge clk);
            waitCnt++;
        end
        #2;
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending predictions, want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
